// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, state encoding and slot helper for the FFT input deserializer
package fft_pkg;

  localparam int IN_WIDTH_DEF  = 16;
  localparam int OUT_WIDTH_DEF = 256;
  localparam int NUM_WORDS_DEF = OUT_WIDTH_DEF / IN_WIDTH_DEF;
  localparam int CNT_WIDTH_DEF = $clog2(NUM_WORDS_DEF) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } deser_state_t;

  // First accepted word lands in the most-significant slot.
  function automatic int slot_lsb(input int idx, input int in_w, input int out_w);
    return out_w - (idx + 1) * in_w;
  endfunction

endpackage

// File: rtl/fft_input_deserializer_if.sv
// rtl/fft_input_deserializer_if.sv - word-in / frame-out handshake bundle of the FFT input deserializer
interface fft_input_deserializer_if #(
  parameter int IN_WIDTH  = fft_pkg::IN_WIDTH_DEF,
  parameter int OUT_WIDTH = fft_pkg::OUT_WIDTH_DEF
);
  localparam int CNT_WIDTH = $clog2(OUT_WIDTH / IN_WIDTH) + 1;

  logic                 sync_clear;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] word_count;
  logic                 frame_done;

  modport slave (
    input  sync_clear, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, word_count, frame_done
  );

  modport master (
    output sync_clear, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, word_count, frame_done
  );

endinterface

// File: rtl/deser_frame_buf.sv
// rtl/deser_frame_buf.sv - one frame register written a word at a time at a slot index
module deser_frame_buf
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int IDX_WIDTH = CNT_WIDTH_DEF - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [IDX_WIDTH-1:0] i_wr_idx,
  input  logic [IN_WIDTH-1:0]  i_wr_data,
  output logic [OUT_WIDTH-1:0] o_frame
);

  localparam int NUM_WORDS = OUT_WIDTH / IN_WIDTH;

  logic [OUT_WIDTH-1:0] r_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame <= '0;
    end else if (i_clr) begin
      r_frame <= '0;
    end else if (i_wr_en) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (i_wr_idx == IDX_WIDTH'(k)) begin
          r_frame[slot_lsb(k, IN_WIDTH, OUT_WIDTH) +: IN_WIDTH] <= i_wr_data;
        end
      end
    end
  end

  assign o_frame = r_frame;

endmodule

// File: rtl/fft_input_deserializer.sv
// rtl/fft_input_deserializer.sv - packs 16-bit samples into 256-bit FFT frames, first word in the MSB slot
// DESER_PINGPONG_EN adds a second frame buffer so collection continues while a frame waits downstream.
module fft_input_deserializer
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  fft_input_deserializer_if.slave  bus
);

  localparam int NUM_WORDS = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_WIDTH = $clog2(NUM_WORDS) + 1;
  localparam int IDX_WIDTH = CNT_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_WORDS);

  deser_state_t         r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_count, w_count_nxt;
  logic                 r_in_ready;
  logic                 r_out_valid, w_out_valid_nxt;
  logic                 r_frame_done, w_done_nxt;
  logic                 w_accept, w_take, w_wr_en;
  logic [IDX_WIDTH-1:0] w_wr_idx;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_take   = r_out_valid & bus.out_ready;
  assign w_wr_idx = r_count[IDX_WIDTH-1:0];

`ifdef DESER_PINGPONG_EN
  logic                 r_col, w_col_nxt;
  logic [OUT_WIDTH-1:0] w_frame0, w_frame1;
`endif

  // in_ready is registered so it stays low through reset and the first clock after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef DESER_PINGPONG_EN
      r_col        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_in_ready   <= (w_state_nxt != ST_FULL);
      r_out_valid  <= w_out_valid_nxt;
      r_frame_done <= w_done_nxt;
`ifdef DESER_PINGPONG_EN
      r_col        <= w_col_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_out_valid_nxt = r_out_valid;
    w_done_nxt      = 1'b0;
    w_wr_en         = 1'b0;
`ifdef DESER_PINGPONG_EN
    w_col_nxt       = r_col;
`endif
    if (bus.sync_clear) begin
      w_state_nxt     = ST_IDLE;
      w_count_nxt     = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
`ifdef DESER_PINGPONG_EN
      // FULL here means the collect buffer is complete but the output buffer is still occupied.
      if (w_take) begin
        w_out_valid_nxt = 1'b0;
        w_done_nxt      = 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (w_accept) begin
            w_wr_en = 1'b1;
            if (r_count == LAST_IDX) begin
              if (!r_out_valid || w_take) begin
                w_col_nxt       = ~r_col;
                w_out_valid_nxt = 1'b1;
                w_count_nxt     = '0;
                w_state_nxt     = ST_IDLE;
              end else begin
                w_count_nxt = FULL_CNT;
                w_state_nxt = ST_FULL;
              end
            end else begin
              w_count_nxt = r_count + 1'b1;
              w_state_nxt = ST_COLLECT;
            end
          end
        end
        ST_FULL: begin
          if (w_take) begin
            w_col_nxt       = ~r_col;
            w_out_valid_nxt = 1'b1;
            w_count_nxt     = '0;
            w_state_nxt     = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_count_nxt     = '0;
          w_out_valid_nxt = 1'b0;
        end
      endcase
`else
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (w_accept) begin
            w_wr_en = 1'b1;
            if (r_count == LAST_IDX) begin
              w_count_nxt     = FULL_CNT;
              w_out_valid_nxt = 1'b1;
              w_state_nxt     = ST_FULL;
            end else begin
              w_count_nxt = r_count + 1'b1;
              w_state_nxt = ST_COLLECT;
            end
          end
        end
        ST_FULL: begin
          if (w_take) begin
            w_count_nxt     = '0;
            w_out_valid_nxt = 1'b0;
            w_done_nxt      = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_count_nxt     = '0;
          w_out_valid_nxt = 1'b0;
        end
      endcase
`endif
    end
  end

`ifdef DESER_PINGPONG_EN
  deser_frame_buf #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_buf0 (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (1'b0),
    .i_wr_en   (w_wr_en & ~r_col),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (bus.in_data),
    .o_frame   (w_frame0)
  );

  deser_frame_buf #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_buf1 (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (1'b0),
    .i_wr_en   (w_wr_en & r_col),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (bus.in_data),
    .o_frame   (w_frame1)
  );

  // The output buffer is always the one not being collected into.
  assign bus.out_data = r_col ? w_frame0 : w_frame1;
`else
  deser_frame_buf #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_buf0 (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (1'b0),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (bus.in_data),
    .o_frame   (bus.out_data)
  );
`endif

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.word_count = r_count;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_fft_input_deserializer.sv
// tb/tb_fft_input_deserializer.sv - scoreboard bench for the FFT input deserializer
module tb_fft_input_deserializer;

  localparam logic [255:0] EXP_BASIC = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] EXP_RAMP  =
    256'hA000A001A002A003A004A005A006A007A008A009A00AA00BA00CA00DA00EA00F;
  localparam logic [255:0] EXP_FEDC  =
    256'hFEDC000100020003000400050006000700080009000A000B000C000D000E000F;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   frames_seen = 0;
  int   done_seen = 0;
  int   cyc = 0;
  logic [255:0] exp_q[$];
  int   deliver_cyc[$];
  logic [15:0] pat[4];

  fft_input_deserializer_if #(.IN_WIDTH(16), .OUT_WIDTH(256)) bus ();

  fft_input_deserializer #(.IN_WIDTH(16), .OUT_WIDTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [255:0] f);
    exp_q.push_back(f);
    n_pushed++;
  endtask

  task automatic send_word(input logic [15:0] d);
    int t;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
  endtask

  // Monitor samples mid-low-phase so inputs driven at the falling edge have settled.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (bus.frame_done) done_seen++;
      if (bus.out_valid && bus.out_ready && !bus.sync_clear) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: got %0h expected none", bus.out_data);
        end else begin
          check("frame_data", bus.out_data, exp_q.pop_front());
        end
        frames_seen++;
        deliver_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    pat[0] = 16'h0123; pat[1] = 16'h4567; pat[2] = 16'h89AB; pat[3] = 16'hCDEF;
    reset          = 1'b1;
    bus.sync_clear = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;

    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_word_count", bus.word_count, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_frame_done", bus.frame_done, 0);
    #2 reset = 1'b0;
    #2 check("in_ready_before_clock", bus.in_ready, 0);
    @(negedge clk);
    check("in_ready_after_clock", bus.in_ready, 1);

    // Basic frame
    bus.out_ready = 1'b1;
    push_frame(EXP_BASIC);
    for (int k = 0; k < 16; k++) send_word(pat[k % 4]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("basic_out_valid", bus.out_valid, 1);
`ifdef DESER_PINGPONG_EN
    check("basic_count_full", bus.word_count, 0);
`else
    check("basic_count_full", bus.word_count, 16);
`endif
    @(negedge clk);
    check("basic_valid_drop", bus.out_valid, 0);
    check("basic_frame_done", bus.frame_done, 1);
    check("basic_count_zero", bus.word_count, 0);
    @(negedge clk);
    check("basic_done_one_cycle", bus.frame_done, 0);

    // Backpressure
    bus.out_ready = 1'b0;
    push_frame(EXP_RAMP);
    for (int k = 0; k < 16; k++) send_word(16'hA000 | 16'(k));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, EXP_RAMP);
`ifdef DESER_PINGPONG_EN
      bus.in_valid = 1'b0;
`else
      bus.in_data = 16'hFEDC;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_word_count", bus.word_count, 16);
`endif
    end
    bus.out_ready = 1'b1;
    push_frame(EXP_FEDC);
    send_word(16'hFEDC);
    for (int k = 1; k < 16; k++) send_word(16'(k));
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Gapped input
    push_frame(EXP_BASIC);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("gap_count_idle", bus.word_count, k);
      @(negedge clk);
      check("gap_count_valid", bus.word_count, k);
      bus.in_data  = pat[k % 4];
      bus.in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("gap_out_valid", bus.out_valid, 1);
    repeat (2) @(negedge clk);

    // sync_clear mid-frame
    for (int k = 0; k < 7; k++) send_word(pat[k % 4]);
    @(negedge clk);
    bus.in_data    = 16'hBAD0;
    bus.in_valid   = 1'b1;
    bus.sync_clear = 1'b1;
    @(negedge clk);
    bus.sync_clear = 1'b0;
    bus.in_valid   = 1'b0;
    check("clr_word_count", bus.word_count, 0);
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_frame_done", bus.frame_done, 0);
    push_frame(EXP_BASIC);
    for (int k = 0; k < 16; k++) send_word(pat[k % 4]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Async reset while a frame waits downstream
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_word(16'hA000 | 16'(k));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("full_out_valid", bus.out_valid, 1);
    #3 reset = 1'b1;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_out_data", bus.out_data, 0);
    check("async_in_ready", bus.in_ready, 0);
    check("async_word_count", bus.word_count, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    push_frame(EXP_BASIC);
    for (int k = 0; k < 16; k++) send_word(pat[k % 4]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

`ifdef DESER_PINGPONG_EN
    // Sustained throughput across three frames
    deliver_cyc.delete();
    for (int f = 0; f < 3; f++) push_frame(EXP_BASIC);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      check("pp_in_ready", bus.in_ready, 1);
      bus.in_data  = pat[i % 4];
      bus.in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (deliver_cyc.size() == 3) begin
      check("pp_spacing_1", deliver_cyc[1] - deliver_cyc[0], 16);
      check("pp_spacing_2", deliver_cyc[2] - deliver_cyc[1], 16);
    end else begin
      check("pp_frames", deliver_cyc.size(), 3);
    end
`endif

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("frames_delivered", frames_seen, n_pushed);
    check("frame_done_count", done_seen, n_pushed);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
